// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store data.
// Define ARB_STARVE_GUARD_EN to bound consecutive data grants while fetch waits.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int OWN_FETCH = 1;
  localparam int OWN_DATA  = 0;

  if (MAX_DATA_RUN < 1) begin : g_bad_run
    $error("mem_arbiter: MAX_DATA_RUN must be at least 1");
  end

  logic [1:0] rd_owner;
  logic       fetch_force;

`ifdef ARB_STARVE_GUARD_EN
  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

  logic [RUN_W-1:0] run_cnt;

  // Counts data wins that happened while fetch was waiting; saturates at the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      run_cnt <= '0;
    end else if (d_gnt && (run_cnt != RUN_MAX)) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  assign fetch_force = (run_cnt == RUN_MAX);
`else
  assign fetch_force = 1'b0;
`endif

  // NOTE: grants are gated by reset_n directly so the memory port is quiet for
  // the whole time reset is held, not just from the next clock edge.
  always_comb begin
    d_gnt  = reset_n && d_req && !(fetch_force && if_req);
    if_gnt = reset_n && if_req && !d_gnt;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  assign mem_en = if_gnt | d_gnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the grant logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_owner <= 2'b00;
    end else begin
      rd_owner <= {if_gnt, d_gnt && !d_we};
    end
  end

  assign if_rvalid = rd_owner[OWN_FETCH];
  assign d_rvalid  = rd_owner[OWN_DATA];
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural one-cycle-latency RAM.
// Starvation expectations follow ARB_STARVE_GUARD_EN as compiled.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] ram [0:255];

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_RUN(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after a read access.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic req, input logic [AW-1:0] addr);
    if_req  = req;
    if_addr = addr;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    d_req   = req;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_if_gnt"}, 32'(if_gnt), 32'd0);
    check({tag, "_d_gnt"}, 32'(d_gnt), 32'd0);
    check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
    check({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
  endtask

  initial begin
    logic guard;
    logic exp_if;
`ifdef ARB_STARVE_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif
    for (int i = 0; i < 256; i++) ram[i] = '0;
    for (int i = 0; i < 8; i++) ram[i] = 16'hA000 + 16'(i);
    ram[8'h10] = 16'hBEEF;
    ram[8'h30] = 16'h5555;
    ram[8'h40] = 16'h6666;

    // Reset with a fetch pending: nothing may be granted while reset is held.
    reset_n = 1'b0;
    set_if(1'b1, 16'h0010);
    set_d(1'b0, 1'b0, '0, '0);
    repeat (3) next_cycle();
    @(negedge clk);
    check_quiet("rst");
    check("rst_mem_addr", 32'(mem_addr), 32'd0);

    // Release: pending fetch is granted in the first cycle out of reset.
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    check("fetch_gnt", 32'(if_gnt), 32'd1);
    check("fetch_mem_en", 32'(mem_en), 32'd1);
    check("fetch_mem_addr", 32'(mem_addr), 32'h0010);
    check("fetch_mem_we", 32'(mem_we), 32'd0);
    next_cycle();
    set_if(1'b0, '0);
    @(negedge clk);
    check("fetch_rvalid", 32'(if_rvalid), 32'd1);
    check("fetch_rdata", 32'(if_rdata), 32'hBEEF);
    check("fetch_d_rvalid", 32'(d_rvalid), 32'd0);
    check("idle_mem_en", 32'(mem_en), 32'd0);

    // Data write then data read of the same word.
    next_cycle();
    set_d(1'b1, 1'b1, 16'h0020, 16'h1234);
    @(negedge clk);
    check("wr_gnt", 32'(d_gnt), 32'd1);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_addr", 32'(mem_addr), 32'h0020);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
    next_cycle();
    set_d(1'b1, 1'b0, 16'h0020, 16'h0000);
    @(negedge clk);
    check("rd_gnt", 32'(d_gnt), 32'd1);
    check("rd_mem_we", 32'(mem_we), 32'd0);
    check("wr_no_d_rvalid", 32'(d_rvalid), 32'd0);
    check("wr_no_if_rvalid", 32'(if_rvalid), 32'd0);
    next_cycle();
    set_d(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("rd_rvalid", 32'(d_rvalid), 32'd1);
    check("rd_rdata", 32'(d_rdata), 32'h1234);
    check("rd_if_rvalid", 32'(if_rvalid), 32'd0);

    // Collision: data wins, fetch follows, responses routed per owner.
    next_cycle();
    set_if(1'b1, 16'h0040);
    set_d(1'b1, 1'b0, 16'h0030, '0);
    @(negedge clk);
    check("col_d_gnt", 32'(d_gnt), 32'd1);
    check("col_if_gnt", 32'(if_gnt), 32'd0);
    check("col_mem_addr", 32'(mem_addr), 32'h0030);
    next_cycle();
    set_d(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("col2_if_gnt", 32'(if_gnt), 32'd1);
    check("col2_mem_addr", 32'(mem_addr), 32'h0040);
    check("col2_d_rvalid", 32'(d_rvalid), 32'd1);
    check("col2_d_rdata", 32'(d_rdata), 32'h5555);
    check("col2_if_rvalid", 32'(if_rvalid), 32'd0);
    next_cycle();
    set_if(1'b0, '0);
    @(negedge clk);
    check("col3_if_rvalid", 32'(if_rvalid), 32'd1);
    check("col3_if_rdata", 32'(if_rdata), 32'h6666);
    check("col3_d_rvalid", 32'(d_rvalid), 32'd0);

    // Continuous data reads with fetch held: guard lets fetch in every 5th cycle.
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      set_if(1'b1, 16'h0010);
      set_d(1'b1, 1'b0, 16'h0020, '0);
      @(negedge clk);
      exp_if = guard && (i % 5 == 4);
      check($sformatf("starve_if_gnt_%0d", i), 32'(if_gnt), 32'(exp_if));
      check($sformatf("starve_d_gnt_%0d", i), 32'(d_gnt), 32'(!exp_if));
    end
    next_cycle();
    set_if(1'b0, '0);
    set_d(1'b0, 1'b0, '0, '0);
    next_cycle();
    @(negedge clk);
    check_quiet("flush");

    // Back-to-back fetch: one grant per cycle, each rvalid one cycle later.
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      if (i < 8) set_if(1'b1, 16'(i));
      else       set_if(1'b0, '0);
      @(negedge clk);
      if (i < 8) begin
        check($sformatf("b2b_gnt_%0d", i), 32'(if_gnt), 32'd1);
        check($sformatf("b2b_addr_%0d", i), 32'(mem_addr), 32'(i));
      end
      if (i > 0) begin
        check($sformatf("b2b_rvalid_%0d", i - 1), 32'(if_rvalid), 32'd1);
        check($sformatf("b2b_rdata_%0d", i - 1), 32'(if_rdata), 32'hA000 + 32'(i - 1));
      end
    end

    // Reset one cycle after a fetch grant drops the response.
    next_cycle();
    set_if(1'b1, 16'h0010);
    @(negedge clk);
    check("mid_if_gnt", 32'(if_gnt), 32'd1);
    next_cycle();
    reset_n = 1'b0;
    set_d(1'b1, 1'b0, 16'h0030, '0);
    #1;
    check_quiet("mid_rst");
    repeat (2) next_cycle();
    @(negedge clk);
    check_quiet("mid_rst_hold");
    next_cycle();
    reset_n = 1'b1;
    set_if(1'b1, 16'h0040);
    set_d(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("rel_if_gnt", 32'(if_gnt), 32'd1);
    check("rel_if_rvalid", 32'(if_rvalid), 32'd0);
    next_cycle();
    set_if(1'b0, '0);
    @(negedge clk);
    check("rel_rvalid", 32'(if_rvalid), 32'd1);
    check("rel_rdata", 32'(if_rdata), 32'h6666);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
